// File: rtl/sc_life_controller.sv
// rtl/sc_life_controller.sv - Frogger game-flow sequencer owning lives decrement, death delay, respawn and invulnerability
module sc_life_controller #(
    parameter int DEATH_CYCLES  = 25_000_000,
    parameter int INVULN_CYCLES = 50_000_000,
    parameter int CNT_W         = 26
) (
    input  logic             SC_LIVECOUNTER_CLOCK_50,
    input  logic             SC_LIVECOUNTER_RESET_InHigh,
    input  logic             SC_LIFECTRL_start_InLow,
    input  logic             SC_LIFECTRL_collision_In,
    input  logic             SC_LIFECTRL_goal_In,
    input  logic [3:0]       SC_LIFECTRL_lives_InBUS,
    output logic             SC_LIFECTRL_cuenta_Out,
    output logic             SC_LIFECTRL_respawn_Out,
    output logic             SC_LIFECTRL_freeze_Out,
    output logic             SC_LIFECTRL_invuln_Out,
    output logic             SC_LIFECTRL_gameover_Out,
    output logic [2:0]       SC_LIFECTRL_state_OutBUS
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PLAY     = 3'd1,
        HIT      = 3'd2,
        DYING    = 3'd3,
        CHECK    = 3'd4,
        RESPAWN  = 3'd5,
        GAMEOVER = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] DEATH_LOAD  = CNT_W'(DEATH_CYCLES - 1);
    localparam logic [CNT_W-1:0] INVULN_LOAD = CNT_W'(INVULN_CYCLES);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] delay_cnt;
    logic [CNT_W-1:0] delay_cnt_next;
    logic             lives_zero;
    logic             cnt_zero;

    assign lives_zero = (SC_LIFECTRL_lives_InBUS == 4'd0);
    assign cnt_zero   = (delay_cnt == '0);

    always_ff @(posedge SC_LIVECOUNTER_CLOCK_50 or posedge SC_LIVECOUNTER_RESET_InHigh) begin
        if (SC_LIVECOUNTER_RESET_InHigh) begin
            state     <= IDLE;
            delay_cnt <= '0;
        end else begin
            state     <= state_next;
            delay_cnt <= delay_cnt_next;
        end
    end

    // One counter serves both the death delay (DYING) and the invulnerability window (PLAY).
    always_comb begin
        state_next     = state;
        delay_cnt_next = delay_cnt;
        case (state)
            IDLE: begin
                if (!SC_LIFECTRL_start_InLow) begin
                    state_next = lives_zero ? GAMEOVER : RESPAWN;
                end
            end
            PLAY: begin
                if (lives_zero) begin
                    state_next     = GAMEOVER;
                    delay_cnt_next = '0;
                end else if (SC_LIFECTRL_collision_In && cnt_zero) begin
                    state_next     = HIT;
                    delay_cnt_next = '0;
                end else begin
                    if (!cnt_zero) begin
                        delay_cnt_next = delay_cnt - 1'b1;
                    end
                    if (SC_LIFECTRL_goal_In) begin
                        state_next = RESPAWN;
                    end
                end
            end
            HIT: begin
                state_next     = DYING;
                delay_cnt_next = DEATH_LOAD;
            end
            DYING: begin
                if (cnt_zero) begin
                    state_next = CHECK;
                end else begin
                    delay_cnt_next = delay_cnt - 1'b1;
                end
            end
            CHECK: begin
                state_next = lives_zero ? GAMEOVER : RESPAWN;
            end
            RESPAWN: begin
                state_next     = PLAY;
                delay_cnt_next = INVULN_LOAD;
            end
            GAMEOVER: begin
                state_next = GAMEOVER;
            end
            default: begin
                state_next     = IDLE;
                delay_cnt_next = '0;
            end
        endcase
    end

    // HIT is only entered with lives nonzero, so decoding cuenta from state alone cannot wrap the counter.
    assign SC_LIFECTRL_cuenta_Out   = (state == HIT);
    assign SC_LIFECTRL_respawn_Out  = (state == RESPAWN);
    assign SC_LIFECTRL_freeze_Out   = (state != PLAY);
    assign SC_LIFECTRL_invuln_Out   = (state == PLAY) && !cnt_zero;
    assign SC_LIFECTRL_gameover_Out = (state == GAMEOVER);
    assign SC_LIFECTRL_state_OutBUS = state;

endmodule

// File: doc/sc_life_controller.md
# sc_life_controller

Game-flow sequencer that owns the lives counter in the Frogger datapath. It watches frog collision and goal events and issues the single-cycle decrement strobe to the lives counter. It runs the death/freeze delay, respawn and post-respawn invulnerability, and declares game over once the lives counter reads zero. It sits between the collision-detect logic and the lives counter, and drives the freeze/respawn controls of the frog and lane movers.

## Interface
Parameters:
- DEATH_CYCLES, 25_000_000: cycles the game stays frozen after a hit (≥1).
- INVULN_CYCLES, 50_000_000: cycles after respawn during which collisions are ignored (≥1).
- CNT_W, 26: width of the shared delay counter; must hold max(DEATH_CYCLES, INVULN_CYCLES).

Ports:
- SC_LIVECOUNTER_CLOCK_50  in  1  system clock, 50 MHz.
- SC_LIVECOUNTER_RESET_InHigh  in  1  asynchronous, active-high reset.
- SC_LIFECTRL_start_InLow  in  1  start button, active low, already debounced.
- SC_LIFECTRL_collision_In  in  1  frog overlaps a hazard (level).
- SC_LIFECTRL_goal_In  in  1  frog reached home row (level).
- SC_LIFECTRL_lives_InBUS  in  4  current lives counter value.
- SC_LIFECTRL_cuenta_Out  out  1  decrement strobe to the lives counter.
- SC_LIFECTRL_respawn_Out  out  1  one-cycle pulse: return frog to start.
- SC_LIFECTRL_freeze_Out  out  1  hold all movers.
- SC_LIFECTRL_invuln_Out  out  1  invulnerability window active.
- SC_LIFECTRL_gameover_Out  out  1  game over indicator.
- SC_LIFECTRL_state_OutBUS  out  3  current state code.

## Operation
- State codes: IDLE=0, PLAY=1, HIT=2, DYING=3, CHECK=4, RESPAWN=5, GAMEOVER=6. Code 7 is unreachable and recovers to IDLE.
- IDLE: freeze=1. On start low: go to GAMEOVER if lives==0, else go to RESPAWN.
- PLAY: freeze=0.
  - If lives==0, go to GAMEOVER with no strobe.
  - Else if collision=1 and invuln counter==0, go to HIT.
  - Else if goal=1, go to RESPAWN. No life is lost.
  - Collision has priority over goal in the same cycle.
  - Collision during invulnerability is ignored, including a simultaneous goal+collision: in that case goal wins.
- HIT: cuenta=1 for exactly this one cycle, freeze=1. Next state is DYING, with the delay counter loaded to DEATH_CYCLES-1.
- DYING: freeze=1. The delay counter decrements each cycle. When it reaches 0, go to CHECK.
- CHECK: freeze=1, one cycle. If lives==0, go to GAMEOVER; else go to RESPAWN.
- RESPAWN: respawn=1 and freeze=1 for one cycle. The delay counter is loaded to INVULN_CYCLES. Next state is PLAY.
- Invulnerability: invuln=1 while the counter is nonzero in PLAY. The counter decrements once per PLAY cycle. It is cleared when leaving PLAY via HIT.
- GAMEOVER: gameover=1, freeze=1, and the state is terminal. Only reset leaves it, which also restores the lives counter to 3.
- cuenta is never asserted when lives==0. This prevents the counter wrapping from 0 to 15.
- The level-sensitive collision input is safe: HIT is entered once per hit because the FSM leaves PLAY immediately.

## Timing
- Reset (async): state=IDLE, delay counter=0. Outputs: cuenta=0, respawn=0, freeze=1, invuln=0, gameover=0, state=0.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.
- Collision sampled high at edge k in PLAY: HIT occupies cycle k..k+1 and cuenta=1 during it. The lives counter updates at edge k+1.
- DYING lasts exactly DEATH_CYCLES cycles. CHECK then samples lives at least DEATH_CYCLES cycles after the strobe, so the counter value is always settled.
- Hit to respawn pulse: DEATH_CYCLES+2 cycles. Hit to PLAY: DEATH_CYCLES+3 cycles.
- Goal sampled at edge k: RESPAWN during cycle k..k+1, PLAY from k+1.
- A start press held across IDLE→RESPAWN has no further effect outside IDLE.
- Reset mid-DYING or mid-HIT: returns to IDLE immediately. A strobe already issued is overridden by the counter's own reset to 3.

## Test plan
Bench parameters: DEATH_CYCLES=4, INVULN_CYCLES=3, with the real lives counter instantiated.

- Reset, then start pulse → 1 cycle RESPAWN with respawn=1, then PLAY. freeze falls and invuln=1 for 3 cycles.
- Collision held high 2 cycles after invuln expires → exactly one cuenta pulse and lives 3→2. 4 DYING cycles, CHECK, then a respawn pulse 6 cycles after the HIT cycle.
- Three hits in total → after the third, lives=0 and CHECK goes to GAMEOVER. gameover=1, and the bench confirms no further cuenta pulses over 100 cycles of collision.
- Collision asserted during invuln, including together with goal → no HIT and lives unchanged; goal triggers RESPAWN.
- Collision and goal together after invuln → HIT taken, lives decremented, no goal respawn.
- Async reset asserted mid-DYING → state=0 and freeze=1 immediately. Lives reads 3 after reset releases.
